// File: rtl/setdata_uart_send.sv
// Write-strobe sequencer for a parallel-bus UART: each data_ready rise yields setup, wrn low pulse, hold.
// Latency: rise sampled at E0 -> SETUP at E2 -> wrn low at E2+SETUP_CYC; one extra request is queued, more are dropped.
module setdata_uart_send #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned WR_LOW_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk_sample,
  input  logic rst,
  input  logic data_ready,
  output logic wrn,
  output logic rdn
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(WR_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pending_q;
  logic             wrn_q;
  logic             s1_q, s2_q, s3_q;

  logic             rise;
  logic             hold_done;
  logic [CNT_W-1:0] cnt_d;

  assign rise      = s2_q & ~s3_q;
  assign hold_done = (state_q == HOLD) && (cnt_q == HOLD_LAST);
  // Counter holds at all-ones rather than wrapping.
  assign cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      wrn_q     <= 1'b1;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
    end else begin
      s1_q <= data_ready;
      s2_q <= s1_q;
      s3_q <= s2_q;

      // A rise coinciding with HOLD completion is consumed directly below instead.
      if (rise && (state_q != IDLE) && !hold_done) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          wrn_q <= 1'b1;
          if (rise) begin
            state_q <= SETUP;
            cnt_q   <= '0;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_q <= STROBE;
            wrn_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            state_q <= HOLD;
            wrn_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HOLD: begin
          if (hold_done) begin
            cnt_q <= '0;
            if (pending_q || rise) begin
              state_q   <= SETUP;
              pending_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          wrn_q   <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign wrn = wrn_q;
  assign rdn = 1'b1;

endmodule

// File: tb/tb_setdata_uart_send.sv
// Directed bench for setdata_uart_send: times every wrn pulse and compares against hand-derived edge times.
// Clock edges fall at 3 + 6k ns.
`timescale 1ns/1ps
module tb_setdata_uart_send;

  logic clk;
  logic rst;
  logic data_ready;
  logic wrn;
  logic rdn;

  int   n_checks;
  int   n_fail;
  int   fall_cnt;
  int   rdn_bad;
  time  fall_q[$];
  time  last_fall;
  time  last_width;

  setdata_uart_send dut (
    .clk_sample (clk),
    .rst        (rst),
    .data_ready (data_ready),
    .wrn        (wrn),
    .rdn        (rdn)
  );

  initial clk = 1'b0;
  always #3 clk = ~clk;

  always @(negedge wrn) begin
    fall_cnt++;
    last_fall = $time;
    fall_q.push_back($time);
  end

  always @(posedge wrn) last_width = $time - last_fall;

  always @(negedge clk) if (rdn !== 1'b1) rdn_bad++;

  task automatic wait_to(input time t);
    if ($time < t) #(t - $time);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_ready = 1'b0;
    #1 rst = 1'b0;
    #1;
    fall_cnt = 0;
    fall_q.delete();
    rdn_bad = 0;
    for (int i = 0; i < 3; i++) begin
      wait_to(10 + 20 * i);
      n_checks++;
      if (wrn !== 1'b1 || rdn !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_outputs t=%0t wrn=%b rdn=%b expected wrn=1 rdn=1", $time, wrn, rdn);
      end
    end
    wait_to(60);
    rst = 1'b1;
    wait_to(250);
    n_checks++;
    if (fall_cnt !== 0 || wrn !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release pulses=%0d wrn=%b expected 0 pulses wrn=1", fall_cnt, wrn);
    end
  endtask

  task automatic test_single();
    wait_to(260);
    data_ready = 1'b1;
    wait_to(284);
    n_checks++;
    if (wrn !== 1'b1) begin
      n_fail++;
      $display("FAIL single_before_fall wrn=%b expected 1", wrn);
    end
    wait_to(286);
    n_checks++;
    if (wrn !== 1'b0) begin
      n_fail++;
      $display("FAIL single_strobe_low wrn=%b expected 0", wrn);
    end
    wait_to(350);
    data_ready = 1'b0;
    n_checks++;
    if (fall_cnt !== 1) begin
      n_fail++;
      $display("FAIL single_count got=%0d expected 1", fall_cnt);
    end
    n_checks++;
    if (last_fall !== 285 || last_width !== 24) begin
      n_fail++;
      $display("FAIL single_timing fall=%0t width=%0t expected fall=285 width=24", last_fall, last_width);
    end
  endtask

  task automatic test_second();
    wait_to(750);
    data_ready = 1'b1;
    wait_to(840);
    data_ready = 1'b0;
    n_checks++;
    if (fall_cnt !== 2 || last_fall !== 777 || last_width !== 24) begin
      n_fail++;
      $display("FAIL second_pulse count=%0d fall=%0t width=%0t expected 2/777/24", fall_cnt, last_fall, last_width);
    end
  endtask

  task automatic test_back_to_back();
    time t0, t1;
    // Sampled pattern from 903: H H L H H H L H H H -> rises seen at 915, 933 (STROBE), 957 (pending).
    wait_to(900); data_ready = 1'b1;
    wait_to(912); data_ready = 1'b0;
    wait_to(918); data_ready = 1'b1;
    wait_to(936); data_ready = 1'b0;
    wait_to(942); data_ready = 1'b1;
    wait_to(960); data_ready = 1'b0;
    wait_to(1100);
    n_checks++;
    if (fall_cnt !== 4) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d expected 4", fall_cnt);
    end
    t0 = (fall_q.size() > 2) ? fall_q[2] : 0;
    t1 = (fall_q.size() > 3) ? fall_q[3] : 0;
    n_checks++;
    if (t0 !== 927 || t1 !== 975) begin
      n_fail++;
      $display("FAIL b2b_falls got=%0t,%0t expected 927,975", t0, t1);
    end
    n_checks++;
    if (last_width !== 24 || wrn !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_width width=%0t wrn=%b expected 24 and 1", last_width, wrn);
    end
  endtask

  task automatic test_reset_mid_strobe();
    wait_to(1200); data_ready = 1'b1;
    wait_to(1218); data_ready = 1'b0;
    wait_to(1230); data_ready = 1'b1;
    wait_to(1246); data_ready = 1'b0;
    wait_to(1247);
    n_checks++;
    if (wrn !== 1'b0 || fall_cnt !== 5) begin
      n_fail++;
      $display("FAIL mid_strobe_low wrn=%b pulses=%0d expected 0 and 5", wrn, fall_cnt);
    end
    wait_to(1248);
    rst = 1'b0;
    #0.5;
    n_checks++;
    if (wrn !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_strobe_abort wrn=%b expected 1", wrn);
    end
    wait_to(1260);
    rst = 1'b1;
    wait_to(1390);
    n_checks++;
    if (fall_cnt !== 5 || wrn !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_strobe_pending_lost pulses=%0d wrn=%b expected 5 and 1", fall_cnt, wrn);
    end
  endtask

  task automatic test_glitch();
    wait_to(1402); data_ready = 1'b1;
    wait_to(1406); data_ready = 1'b0;
    wait_to(1500);
    n_checks++;
    if (fall_cnt !== 5) begin
      n_fail++;
      $display("FAIL glitch pulses=%0d expected 5", fall_cnt);
    end
  endtask

  task automatic test_release_high();
    wait_to(1510);
    rst = 1'b0;
    data_ready = 1'b1;
    wait_to(1520);
    rst = 1'b1;
    wait_to(1560);
    data_ready = 1'b0;
    wait_to(1620);
    n_checks++;
    if (fall_cnt !== 6 || last_fall !== 1545 || last_width !== 24) begin
      n_fail++;
      $display("FAIL release_high count=%0d fall=%0t width=%0t expected 6/1545/24", fall_cnt, last_fall, last_width);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    fall_cnt   = 0;
    rdn_bad    = 0;
    last_fall  = 0;
    last_width = 0;
    test_reset();
    test_single();
    test_second();
    test_back_to_back();
    test_reset_mid_strobe();
    test_glitch();
    test_release_high();
    n_checks++;
    if (rdn_bad !== 0) begin
      n_fail++;
      $display("FAIL rdn_constant bad_samples=%0d expected 0", rdn_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
